// File: rtl/sram_rom_arb_pkg.sv
// Shared definitions for the ROM read arbiter: width helpers and the
// pending-response record carried by the response stage.
package sram_rom_arb_pkg;

  // Widest owner index the pending record can hold (NREQ <= 256).
  localparam int PEND_OWN_W = 8;

  // Word-address width for a ROM of the given depth.
  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Requester-index width; never collapses to zero bits.
  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Response stage: a read is in flight / waiting, and who owns it.
  typedef struct packed {
    logic                  vld;
    logic [PEND_OWN_W-1:0] own;
  } pend_t;

endpackage

// File: rtl/sram_rom_arb_rr.sv
// Combinational round-robin picker: first set REQ bit at or after PTR,
// wrapping. Reusable by any shared-resource controller.
module rr_arb
  import sram_rom_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = iw_of(N)
) (
  input  logic [N-1:0]  REQ,
  input  logic [IW-1:0] PTR,
  input  logic          EN,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] GNT_IDX
);

  // Walk the requesters in priority order starting at PTR; first hit wins.
  always_comb begin
    logic          found;
    int            idx;
    logic [IW-1:0] idx_l;
    GNT     = '0;
    GNT_IDX = '0;
    found   = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(PTR) + k;
      if (idx >= N) idx = idx - N;
      idx_l = IW'(idx);
      if (EN && !found && REQ[idx_l]) begin
        found      = 1'b1;
        GNT[idx_l] = 1'b1;
        GNT_IDX    = idx_l;
      end
    end
  end

endmodule

// File: rtl/sram_rom_arb.sv
// Shares one single-port, 1-cycle-latency synchronous ROM among NREQ
// valid/ready readers. Round-robin grant, one read in flight, response held
// (ROM address register frozen) until its owner accepts it.
module sram_rom_arb
  import sram_rom_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1024,
  parameter  int NREQ  = 2,
  localparam int AW    = aw_of(DEPTH),
  localparam int IW    = iw_of(NREQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ_VAL,
  output logic [NREQ-1:0]    REQ_RDY,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  output logic [NREQ-1:0]    RESP_VAL,
  input  logic [NREQ-1:0]    RESP_RDY,
  output logic [WIDTH-1:0]   RESP_DATA,
  output logic               ROM_EN,
  output logic [AW-1:0]      ROM_ADDR,
  input  logic [WIDTH-1:0]   ROM_DO
);

  pend_t                  pend_q, pend_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   s1_vld;
  logic [IW-1:0]          s1_own;
  logic [NREQ-1:0][AW-1:0] req_addr_a;
  logic                   free, arb_en, grant, resp_acc;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   unused_own_hi;

  assign req_addr_a    = REQ_ADDR;
  assign s1_vld        = pend_q.vld;
  assign s1_own        = pend_q.own[IW-1:0];
  assign unused_own_hi = ^pend_q.own;

  // The ROM can take a new address only when nothing is pending or the
  // pending word leaves this cycle; reset blocks grants so nothing is
  // issued while RST is high.
  assign free   = !s1_vld || RESP_RDY[s1_own];
  assign arb_en = free && !RST;

  rr_arb #(.N(NREQ)) u_rr (
    .REQ     (REQ_VAL),
    .PTR     (rr_ptr_q),
    .EN      (arb_en),
    .GNT     (gnt),
    .GNT_IDX (gnt_idx)
  );

  assign grant     = |gnt;
  assign REQ_RDY   = gnt;
  assign ROM_EN    = grant;
  assign ROM_ADDR  = grant ? req_addr_a[gnt_idx] : '0;
  assign RESP_DATA = ROM_DO;

  // Steer the pending response's valid to its owner; suppressed during reset
  // so a read accepted just before reset never surfaces.
  always_comb begin
    RESP_VAL = '0;
    if (s1_vld && !RST) RESP_VAL[s1_own] = 1'b1;
  end

  assign resp_acc = |(RESP_VAL & RESP_RDY);

  // Grant loads the response stage and moves priority past the winner;
  // an accept with no new grant empties the stage.
  always_comb begin
    pend_d   = pend_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      pend_d.vld = 1'b1;
      pend_d.own = PEND_OWN_W'(gnt_idx);
      rr_ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end else if (resp_acc) begin
      pend_d.vld = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_sram_rom_arb.sv
// Directed checks on a 2-requester arbiter plus a randomized run on a
// 4-requester one against a small reference model.
module tb_sram_rom_arb;

  localparam logic [31:0] BASE = 32'hA000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 2-requester instance
  logic [1:0]       v2, rdy2, rv2, rr2;
  logic [1:0][9:0]  a2;
  logic [31:0]      rd2, do2;
  logic             en2;
  logic [9:0]       ra2, rq2;

  sram_rom_arb #(.WIDTH(32), .DEPTH(1024), .NREQ(2)) dut2 (
    .CLK(clk), .RST(rst), .REQ_VAL(v2), .REQ_RDY(rdy2), .REQ_ADDR(a2),
    .RESP_VAL(rv2), .RESP_RDY(rr2), .RESP_DATA(rd2), .ROM_EN(en2),
    .ROM_ADDR(ra2), .ROM_DO(do2)
  );

  always_ff @(posedge clk) if (en2) rq2 <= ra2;
  assign do2 = BASE + {22'd0, rq2};

  // 4-requester instance
  logic [3:0]       v4, rdy4, rv4, rr4;
  logic [3:0][9:0]  a4;
  logic [31:0]      rd4, do4;
  logic             en4;
  logic [9:0]       ra4, rq4;

  sram_rom_arb #(.WIDTH(32), .DEPTH(1024), .NREQ(4)) dut4 (
    .CLK(clk), .RST(rst), .REQ_VAL(v4), .REQ_RDY(rdy4), .REQ_ADDR(a4),
    .RESP_VAL(rv4), .RESP_RDY(rr4), .RESP_DATA(rd4), .ROM_EN(en4),
    .ROM_ADDR(ra4), .ROM_DO(do4)
  );

  always_ff @(posedge clk) if (en4) rq4 <= ra4;
  assign do4 = BASE + {22'd0, rq4};

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    cyc();
    rst = 1'b1; v2 = '0; v4 = '0; rr2 = '0; rr4 = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v2 = 2'b11; a2[0] = 10'h1; a2[1] = 10'h2; rr2 = 2'b11;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      smp();
      checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL reset_rdy c=%0d got=%b exp=00", c, rdy2); end
      checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL reset_rv c=%0d got=%b exp=00", c, rv2); end
      checks++; if (en2 !== 1'b0) begin errors++; $display("FAIL reset_en c=%0d got=%b exp=0", c, en2); end
    end
    cyc(); rst = 1'b0; smp();
    checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL reset_first_gnt got=%b exp=01", rdy2); end
    checks++; if (en2 !== 1'b1 || ra2 !== 10'h1) begin errors++; $display("FAIL reset_first_addr got en=%b addr=%h exp en=1 addr=001", en2, ra2); end
    cyc(); v2 = 2'b00; smp();
    checks++; if (rv2 !== 2'b01 || rd2 !== 32'hA000_0001) begin errors++; $display("FAIL reset_first_resp got rv=%b d=%h exp rv=01 d=a0000001", rv2, rd2); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    apply_reset();
    rr2 = 2'b11; v2 = 2'b01;
    for (int k = 0; k < 3; k++) begin
      a2[0] = 10'(5 + k);
      smp();
      checks++; if (rdy2 !== 2'b01 || en2 !== 1'b1 || ra2 !== 10'(5 + k)) begin errors++; $display("FAIL b2b_gnt k=%0d got rdy=%b en=%b addr=%h exp rdy=01 en=1 addr=%h", k, rdy2, en2, ra2, 10'(5 + k)); end
      if (k > 0) begin
        exp_d = BASE + 32'(4 + k);
        checks++; if (rv2 !== 2'b01 || rd2 !== exp_d) begin errors++; $display("FAIL b2b_resp k=%0d got rv=%b d=%h exp rv=01 d=%h", k, rv2, rd2, exp_d); end
      end
      cyc();
    end
    v2 = 2'b00; smp();
    checks++; if (rv2 !== 2'b01 || rd2 !== 32'hA000_0007 || rdy2 !== 2'b00) begin errors++; $display("FAIL b2b_last got rv=%b d=%h rdy=%b exp rv=01 d=a0000007 rdy=00", rv2, rd2, rdy2); end
    cyc(); smp();
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL b2b_idle got rv=%b exp=00", rv2); end
  endtask

  task automatic test_alternate();
    logic [1:0]  eg, pg;
    logic [31:0] exp_d;
    apply_reset();
    rr2 = 2'b11; v2 = 2'b11; a2[0] = 10'h10; a2[1] = 10'h20;
    pg = 2'b00;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      smp();
      checks++; if (rdy2 !== eg) begin errors++; $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, rdy2, eg); end
      if (k > 0) begin
        exp_d = (pg == 2'b01) ? 32'hA000_0010 : 32'hA000_0020;
        checks++; if (rv2 !== pg || rd2 !== exp_d) begin errors++; $display("FAIL alt_resp k=%0d got rv=%b d=%h exp rv=%b d=%h", k, rv2, rd2, pg, exp_d); end
      end
      pg = eg;
      cyc();
    end
    v2 = 2'b00; smp();
    checks++; if (rv2 !== 2'b10 || rd2 !== 32'hA000_0020) begin errors++; $display("FAIL alt_drain got rv=%b d=%h exp rv=10 d=a0000020", rv2, rd2); end
    cyc();
  endtask

  task automatic test_backpressure();
    apply_reset();
    rr2 = 2'b11; v2 = 2'b01; a2[0] = 10'h3;
    smp();
    checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL bp_gnt0 got=%b exp=01", rdy2); end
    cyc();
    v2 = 2'b10; a2[1] = 10'h20; rr2 = 2'b10;
    for (int c = 0; c < 4; c++) begin
      smp();
      checks++; if (rv2 !== 2'b01 || rd2 !== 32'hA000_0003) begin errors++; $display("FAIL bp_hold c=%0d got rv=%b d=%h exp rv=01 d=a0000003", c, rv2, rd2); end
      checks++; if (en2 !== 1'b0 || rdy2 !== 2'b00) begin errors++; $display("FAIL bp_stall c=%0d got en=%b rdy=%b exp en=0 rdy=00", c, en2, rdy2); end
      cyc();
    end
    rr2 = 2'b11; smp();
    checks++; if (rv2 !== 2'b01 || rdy2 !== 2'b10 || en2 !== 1'b1 || ra2 !== 10'h20) begin errors++; $display("FAIL bp_release got rv=%b rdy=%b en=%b addr=%h exp rv=01 rdy=10 en=1 addr=020", rv2, rdy2, en2, ra2); end
    cyc(); v2 = 2'b00; smp();
    checks++; if (rv2 !== 2'b10 || rd2 !== 32'hA000_0020) begin errors++; $display("FAIL bp_resp1 got rv=%b d=%h exp rv=10 d=a0000020", rv2, rd2); end
    cyc();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rr2 = 2'b11; v2 = 2'b01; a2[0] = 10'h8; a2[1] = 10'h21;
    smp();
    checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL rmid_gnt got=%b exp=01", rdy2); end
    cyc(); rst = 1'b1; v2 = 2'b11; smp();
    checks++; if (rv2 !== 2'b00 || rdy2 !== 2'b00 || en2 !== 1'b0) begin errors++; $display("FAIL rmid_in_rst got rv=%b rdy=%b en=%b exp 00 00 0", rv2, rdy2, en2); end
    cyc(); rst = 1'b0; smp();
    checks++; if (rv2 !== 2'b00) begin errors++; $display("FAIL rmid_after_rv got=%b exp=00", rv2); end
    checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL rmid_after_gnt got=%b exp=01", rdy2); end
    cyc(); v2 = 2'b00; smp();
    checks++; if (rv2 !== 2'b01 || rd2 !== 32'hA000_0008) begin errors++; $display("FAIL rmid_resp got rv=%b d=%h exp rv=01 d=a0000008", rv2, rd2); end
    cyc();
  endtask

  task automatic test_random_fair();
    logic [3:0] pend, eg, erv;
    logic [9:0] paddr [4];
    int         wcnt  [4];
    logic       m_vld, free_m, found, fair_ok;
    int         m_own, m_ptr, w, idx;
    logic [9:0] m_addr;
    apply_reset();
    pend = '0; m_vld = 1'b0; m_own = 0; m_ptr = 0; m_addr = '0;
    for (int i = 0; i < 4; i++) begin paddr[i] = '0; wcnt[i] = 0; end
    for (int cy = 0; cy < 2000; cy++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          paddr[i] = 10'($urandom_range(0, 1023));
        end
        a4[i]  = paddr[i];
        rr4[i] = ($urandom_range(0, 3) != 0);
      end
      v4 = pend;
      smp();
      free_m = !m_vld || rr4[m_own];
      eg = '0; found = 1'b0; w = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (free_m && !found && pend[idx]) begin found = 1'b1; w = idx; eg[idx] = 1'b1; end
      end
      erv = '0;
      if (m_vld) erv[m_own] = 1'b1;
      checks++; if (rdy4 !== eg) begin errors++; $display("FAIL rnd_gnt cy=%0d got=%b exp=%b", cy, rdy4, eg); end
      checks++; if (rv4 !== erv) begin errors++; $display("FAIL rnd_rv cy=%0d got=%b exp=%b", cy, rv4, erv); end
      if (m_vld) begin
        checks++; if (rd4 !== BASE + 32'(m_addr)) begin errors++; $display("FAIL rnd_data cy=%0d got=%h exp=%h", cy, rd4, BASE + 32'(m_addr)); end
        if (!rr4[m_own]) begin
          checks++; if (en4 !== 1'b0) begin errors++; $display("FAIL rnd_stall_en cy=%0d got=%b exp=0", cy, en4); end
        end
      end
      if (found) begin
        checks++; if (en4 !== 1'b1 || ra4 !== paddr[w]) begin errors++; $display("FAIL rnd_addr cy=%0d got en=%b addr=%h exp en=1 addr=%h", cy, en4, ra4, paddr[w]); end
        fair_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (i == w) wcnt[i] = 0;
          else if (pend[i]) wcnt[i]++;
          if (wcnt[i] > 3) fair_ok = 1'b0;
        end
        checks++; if (!fair_ok) begin errors++; $display("FAIL rnd_fair cy=%0d waits=%0d,%0d,%0d,%0d exp<=3", cy, wcnt[0], wcnt[1], wcnt[2], wcnt[3]); end
        m_vld = 1'b1; m_own = w; m_addr = paddr[w]; m_ptr = (w + 1) % 4; pend[w] = 1'b0;
      end else if (m_vld && rr4[m_own]) begin
        m_vld = 1'b0;
      end
      cyc();
    end
    v4 = '0; rr4 = '0;
  endtask

  initial begin
    rst = 1'b1;
    v2 = '0; rr2 = '0; a2 = '0;
    v4 = '0; rr4 = '0; a4 = '0;
    test_reset();
    test_back_to_back();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random_fair();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
